// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: picks PC+1, branch or jump target,
// inserts fetch bubbles after redirects, and tracks idle/halt state and a redirect count.
module pc_sequencer #(
    parameter logic [7:0]  RESET_PC   = 8'h00,
    parameter int unsigned IMEM_DEPTH = 36,
    parameter int unsigned BR_FLUSH   = 2,
    parameter int unsigned JMP_FLUSH  = 1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       br_taken,
    input  logic [7:0] br_target,
    input  logic       jmp_valid,
    input  logic [7:0] jmp_target,
    input  logic       halt_req,
    output logic [7:0] PC,
    output logic       fetch_en,
    output logic       flush,
    output logic [1:0] state,
    output logic [7:0] redirect_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_PC = 8'(IMEM_DEPTH - 1);
    localparam logic [2:0] BR_CNT  = 3'(BR_FLUSH);
    localparam logic [2:0] JMP_CNT = 3'(JMP_FLUSH);

    state_t     cur;
    logic [2:0] flush_cnt;

    assign state = cur;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            cur          <= IDLE;
            PC           <= RESET_PC;
            fetch_en     <= 1'b0;
            flush        <= 1'b0;
            redirect_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            case (cur)
                IDLE: begin
                    if (start) begin
                        cur      <= RUN;
                        fetch_en <= 1'b1;
                    end
                end
                RUN: begin
                    // Priority: halt, branch (older instruction), jump, stall, end of program.
                    if (halt_req) begin
                        cur      <= HALT;
                        fetch_en <= 1'b0;
                    end else if (br_taken) begin
                        PC        <= br_target;
                        cur       <= FLUSH;
                        flush_cnt <= BR_CNT;
                        fetch_en  <= 1'b0;
                        flush     <= 1'b1;
                        if (redirect_cnt != '1)
                            redirect_cnt <= redirect_cnt + 8'd1;
                    end else if (jmp_valid) begin
                        PC        <= jmp_target;
                        cur       <= FLUSH;
                        flush_cnt <= JMP_CNT;
                        fetch_en  <= 1'b0;
                        flush     <= 1'b1;
                        if (redirect_cnt != '1)
                            redirect_cnt <= redirect_cnt + 8'd1;
                    end else if (stall) begin
                        PC <= PC;
                    end else if (PC == LAST_PC) begin
                        cur      <= HALT;
                        fetch_en <= 1'b0;
                    end else begin
                        PC <= PC + 8'd1;
                    end
                end
                FLUSH: begin
                    if (halt_req) begin
                        cur       <= HALT;
                        flush     <= 1'b0;
                        flush_cnt <= '0;
                    end else if (flush_cnt == 3'd1) begin
                        cur       <= RUN;
                        flush     <= 1'b0;
                        fetch_en  <= 1'b1;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                HALT: begin
                    cur <= HALT;
                end
                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter for the RISC fetch stage and sequences it.
- Each cycle it chooses the next PC from sequential (PC+1), resolved-branch target or jump target.
- After every redirect it drives fetch_en low for a programmable number of cycles, so the instruction-fetch stage loads NOP bubbles.
- Also tracks halt and start-up state and counts redirects for debug.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- IMEM_DEPTH, 36, number of instruction-memory entries; the last valid PC is IMEM_DEPTH-1.
- BR_FLUSH, 2, bubble cycles after a taken branch. Must be 1..7.
- JMP_FLUSH, 1, bubble cycles after a jump. Must be 1..7.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge CLK.
- start  input  1  leave IDLE and begin fetching.
- stall  input  1  hazard-unit hold request; freezes PC.
- br_taken  input  1  EX stage: conditional branch (BZ/BNZ) resolved taken.
- br_target  input  8  branch target address.
- jmp_valid  input  1  jump (JMP/JML/JMR) decoded.
- jmp_target  input  8  jump target address.
- halt_req  input  1  stop fetching permanently (until reset).
- PC  output  8  current fetch address; registered.
- fetch_en  output  1  1 = fetch real instruction; 0 = fetch stage inserts NOP. Drives branch_predict.
- flush  output  1  1 = downstream squashes in-flight wrong-path instructions.
- state  output  2  IDLE=0, RUN=1, FLUSH=2, HALT=3.
- redirect_cnt  output  8  number of accepted redirects; saturates at 255.

Behaviour:
- Reset: when reset==0 at posedge CLK, outputs load PC=RESET_PC, state=IDLE, fetch_en=0, flush=0, redirect_cnt=0 and the internal flush counter=0.
  - Reset overrides every other input in any state, including mid-flush.
- All outputs are registered. An input change is visible on the outputs one posedge later.
- fetch_en=1 only in RUN. flush=1 only in FLUSH.
- IDLE:
  - PC holds.
  - start=1 moves to RUN; PC stays RESET_PC, so the first fetch is at RESET_PC.
  - All other inputs are ignored.
- RUN: each cycle, the first matching case in this order applies.
  1. halt_req=1: go to HALT; PC holds.
  2. br_taken=1: PC<=br_target, go to FLUSH, flush counter<=BR_FLUSH, redirect_cnt+1. Branch beats jump because it is the older instruction.
  3. jmp_valid=1: PC<=jmp_target, go to FLUSH, flush counter<=JMP_FLUSH, redirect_cnt+1.
  4. stall=1: PC holds; stay in RUN with fetch_en=1, so the same PC is re-fetched.
  5. PC==IMEM_DEPTH-1 with no other event: go to HALT; PC holds at IMEM_DEPTH-1 (end of program).
  6. Otherwise: PC<=PC+1, computed as 8-bit with natural wrap.
- FLUSH:
  - PC holds the target; fetch_en=0, flush=1.
  - Counter decrements each cycle. When counter==1 the next state is RUN, and the target is fetched in the first RUN cycle.
  - br_taken, jmp_valid and stall are ignored (wrong-path or irrelevant).
  - halt_req=1 goes to HALT immediately.
- HALT:
  - PC holds; fetch_en=0, flush=0.
  - start is ignored; only reset leaves HALT.
- redirect_cnt: increments only when a redirect is accepted in RUN, never in FLUSH. Holds at 255 once reached.
- Targets are used unchecked. A target ≥IMEM_DEPTH is fetched as-is (fetch memory returns zero). It halts on the next sequential step only if it equals IMEM_DEPTH-1; otherwise PC counts up and wraps at 8'hFF→8'h00.

Test Plan:
- Reset and start: hold reset=0 for 2 cycles, then reset=1 and start=1 for one cycle. Required: state IDLE→RUN, then PC=0,1,2,3 on successive cycles with fetch_en=1.
- Taken branch: at PC=5, pulse br_taken=1 with br_target=8'h14. Required next cycle: PC=0x14, state=FLUSH, flush=1, fetch_en=0 for 2 cycles. Then RUN, PC=0x14, then 0x15; redirect_cnt=1.
- Branch and jump together: br_taken=1 (target 0x0A) and jmp_valid=1 (target 0x20) in the same cycle. Required: PC=0x0A, flush lasts 2 cycles. A further jmp_valid during FLUSH is ignored; redirect_cnt increments by 1 only.
- Stall versus sequential: stall=1 for 3 cycles at PC=7. Required: PC stays 7 with fetch_en=1, then advances to 8 the cycle after stall drops. stall=1 together with jmp_valid (target 0x03): jump wins, PC=3.
- End of program and halt: run sequentially to PC=35. Required: state=HALT next cycle, PC stays 35, fetch_en=0, and start=1 has no effect. Separately, halt_req=1 in FLUSH gives HALT the next cycle.
- Reset mid-flush and saturation: drive reset=0 during the 2nd FLUSH cycle. Required: PC=0, IDLE, flush=0, redirect_cnt=0 next cycle. Then perform 260 jumps; required redirect_cnt=255.
